// File: rtl/e1ofn_sync_bridge.sv
// rtl/e1ofn_sync_bridge.sv - e1ofN four-phase <-> synchronous valid/ready bridge
//
// Purpose: connects one clocked block to the async NoC. The receive half
// decodes an incoming e1ofN token into a binary word. The send half encodes
// a binary word onto an outgoing e1ofN channel. The two halves share only
// the clock and the reset.
//
// Ports:
//   CLK       clock, rising edge
//   _RESET    asynchronous active-low reset
//   in_d      incoming rails, digit i = in_d[i*N +: N]
//   in_e      enable/ack to the upstream async sender
//   rx_data   received word
//   rx_valid  rx_data holds an unconsumed token
//   rx_ready  consumer accepts rx_data this cycle
//   tx_data   word to send
//   tx_valid  producer offers tx_data
//   tx_ready  bridge can accept tx_data this cycle
//   out_d     outgoing rails, registered
//   out_e     enable/ack from the downstream async receiver
module e1ofn_sync_bridge #(
  parameter  int M = 9,
  parameter  int N = 2,
  localparam int B = $clog2(N),
  localparam int W = M * B
) (
  input  logic           CLK,
  input  logic           _RESET,
  input  logic [M*N-1:0] in_d,
  output logic           in_e,
  output logic [W-1:0]   rx_data,
  output logic           rx_valid,
  input  logic           rx_ready,
  input  logic [W-1:0]   tx_data,
  input  logic           tx_valid,
  output logic           tx_ready,
  output logic [M*N-1:0] out_d,
  input  logic           out_e
);

  typedef enum logic {RX_IDLE, RX_ACK} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_WAIT_EN, TX_WAIT_ACK} tx_state_t;

  // Two-flop synchronizers; only the second stage is ever used.
  logic [M*N-1:0] in_s1_q, in_s2_q;
  logic           oe_s1_q, oe_s2_q;

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      in_s1_q <= '0;
      in_s2_q <= '0;
      oe_s1_q <= 1'b0;
      oe_s2_q <= 1'b0;
    end else begin
      in_s1_q <= in_d;
      in_s2_q <= in_s1_q;
      oe_s1_q <= out_e;
      oe_s2_q <= oe_s1_q;
    end
  end

  // Per-digit decode. A digit counts as complete only when exactly one rail
  // is high, so a multi-hot digit (protocol violation) blocks capture.
  logic [M-1:0] dig_ok;
  logic [W-1:0] rx_word;
  logic         all_complete;
  logic         all_low;

  for (genvar g = 0; g < M; g++) begin : g_dec
    logic [N-1:0] rails;
    logic         ok;
    logic [B-1:0] val;

    assign rails = in_s2_q[g*N +: N];

    always_comb begin
      ok  = ($countones(rails) == 1);
      val = '0;
      for (int r = 0; r < N; r++) begin
        if (rails[r]) val = B'(r);
      end
    end

    assign dig_ok[g]           = ok;
    assign rx_word[g*B +: B]   = val;
  end

  assign all_complete = &dig_ok;
  assign all_low      = ~|in_s2_q;

  // ---------------- receive FSM ----------------
  rx_state_t    rx_state_q, rx_state_d;
  logic         rx_valid_q, rx_valid_d;
  logic [W-1:0] rx_data_q, rx_data_d;
  logic         rx_capture;

  // A full buffer leaves the FSM in RX_IDLE with in_e high: the sender keeps
  // its rails up until the word is consumed and capture can happen.
  assign rx_capture = (rx_state_q == RX_IDLE) && all_complete && !rx_valid_q;

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      rx_state_q <= RX_IDLE;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE: if (rx_capture) rx_state_d = RX_ACK;
      RX_ACK:  if (all_low)    rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    in_e       = (rx_state_q == RX_IDLE);
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    if (rx_capture) begin
      rx_data_d  = rx_word;
      rx_valid_d = 1'b1;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

  // ---------------- send FSM ----------------
  tx_state_t      tx_state_q, tx_state_d;
  logic [W-1:0]   tx_word_q, tx_word_d;
  logic [M*N-1:0] out_d_q, out_d_d;
  logic [M*N-1:0] tx_enc;

  for (genvar g = 0; g < M; g++) begin : g_enc
    for (genvar r = 0; r < N; r++) begin : g_rail
      assign tx_enc[g*N + r] = (tx_word_q[g*B +: B] == B'(r));
    end
  end

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      tx_state_q <= TX_IDLE;
      tx_word_q  <= '0;
      out_d_q    <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_word_q  <= tx_word_d;
      out_d_q    <= out_d_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      TX_IDLE:     if (tx_valid) tx_state_d = TX_WAIT_EN;
      TX_WAIT_EN:  if (oe_s2_q)  tx_state_d = TX_WAIT_ACK;
      TX_WAIT_ACK: if (!oe_s2_q) tx_state_d = TX_IDLE;
      default:     tx_state_d = TX_IDLE;
    endcase
  end

  // The rails move only in a single registered step per transition, so a
  // digit is never seen half-asserted or multi-hot downstream.
  always_comb begin
    tx_ready  = (tx_state_q == TX_IDLE);
    tx_word_d = tx_word_q;
    out_d_d   = out_d_q;
    case (tx_state_q)
      TX_IDLE:     if (tx_valid) tx_word_d = tx_data;
      TX_WAIT_EN:  if (oe_s2_q)  out_d_d = tx_enc;
      TX_WAIT_ACK: if (!oe_s2_q) out_d_d = '0;
      default:     out_d_d = '0;
    endcase
  end

  assign out_d = out_d_q;

endmodule

// File: tb/tb_e1ofn_sync_bridge.sv
// tb/tb_e1ofn_sync_bridge.sv - self-checking bench for e1ofn_sync_bridge
module tb_e1ofn_sync_bridge;
  localparam int M    = 9;
  localparam int N    = 2;
  localparam int B    = 1;
  localparam int W    = 9;
  localparam int RW   = M * N;
  localparam int NTOK = 30;

  logic          CLK;
  logic          rst_n;
  logic [RW-1:0] in_d;
  logic          in_e;
  logic [W-1:0]  rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [W-1:0]  tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [RW-1:0] out_d;
  logic          out_e;

  int checks = 0;
  int errors = 0;

  e1ofn_sync_bridge #(.M(M), .N(N)) dut (
    .CLK(CLK), ._RESET(rst_n),
    .in_d(in_d), .in_e(in_e),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .out_d(out_d), .out_e(out_e)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Digit i carries value v by raising rail i*N+v.
  function automatic logic [RW-1:0] enc(input logic [W-1:0] w);
    logic [RW-1:0] r;
    r = '0;
    for (int i = 0; i < M; i++) r[i*N + ((int'(w) >> (i*B)) % N)] = 1'b1;
    return r;
  endfunction

  // Returns {complete, word}: complete only if every digit is exactly one-hot.
  function automatic logic [W:0] dec(input logic [RW-1:0] r);
    int   word, cnt, idx;
    logic ok;
    word = 0;
    ok   = 1'b1;
    for (int i = 0; i < M; i++) begin
      cnt = 0;
      idx = 0;
      for (int v = 0; v < N; v++) if (r[i*N + v]) begin cnt++; idx = v; end
      if (cnt != 1) ok = 1'b0;
      word = word + idx * (N ** i);
    end
    return {ok, W'(word)};
  endfunction

  typedef struct packed {
    logic [RW-1:0] rails;
    logic          cap;
    logic [W-1:0]  word;
  } rx_vec_t;

  rx_vec_t vt[6];

  logic [W-1:0] rx_q[$];
  logic [W-1:0] tx_q[$];

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // ---------- randomized processes ----------
  task automatic rx_sender();
    logic [W-1:0] w;
    int n;
    for (int t = 0; t < NTOK; t++) begin
      n = 0;
      while (in_e !== 1'b1 && n < 60) begin tick(1); n++; end
      if (n >= 60) begin tmo("rand_rx_en"); return; end
      tick($urandom_range(0, 3));
      w = W'($urandom_range(0, (1 << W) - 1));
      rx_q.push_back(w);
      in_d = enc(w);
      n = 0;
      while (in_e !== 1'b0 && n < 60) begin tick(1); n++; end
      if (n >= 60) begin tmo("rand_rx_ack"); return; end
      tick($urandom_range(0, 3));
      in_d = '0;
    end
  endtask

  task automatic rx_consumer();
    int got, cyc;
    got = 0;
    cyc = 0;
    while (got < NTOK && cyc < 4000) begin
      rx_ready = 1'($urandom_range(0, 1));
      @(negedge CLK);
      if (rx_valid && rx_ready) begin
        if (rx_q.size() == 0) check("rand_rx_extra", 32'(rx_valid), 0);
        else check("rand_rx_data", 32'(rx_data), 32'(rx_q.pop_front()));
        got++;
      end
      tick(1);
      cyc++;
    end
    if (got < NTOK) tmo("rand_rx_count");
    rx_ready = 1'b0;
  endtask

  task automatic tx_producer();
    logic [W-1:0] w;
    int n;
    for (int t = 0; t < NTOK; t++) begin
      tx_valid = 1'b0;
      tick($urandom_range(0, 3));
      w        = W'($urandom_range(0, (1 << W) - 1));
      tx_data  = w;
      tx_valid = 1'b1;
      n = 0;
      forever begin
        @(negedge CLK);
        if (tx_ready) begin
          tx_q.push_back(w);
          tick(1);
          break;
        end
        tick(1);
        n++;
        if (n >= 80) break;
      end
      tx_valid = 1'b0;
      tx_data  = W'($urandom);
      if (n >= 80) begin tmo("rand_tx_accept"); return; end
    end
  endtask

  task automatic tx_responder();
    logic [W:0] d;
    int n;
    for (int t = 0; t < NTOK; t++) begin
      n = 0;
      d = dec(out_d);
      while (!d[W] && n < 80) begin
        if (out_d != '0) check("rand_tx_glitch", 32'(d[W]), 1);
        tick(1);
        d = dec(out_d);
        n++;
      end
      if (n >= 80) begin tmo("rand_tx_rails"); return; end
      if (tx_q.size() == 0) check("rand_tx_extra", 32'(out_d), 0);
      else check("rand_tx_data", 32'(d[W-1:0]), 32'(tx_q.pop_front()));
      tick($urandom_range(0, 3));
      out_e = 1'b0;
      n = 0;
      while (out_d != '0 && n < 60) begin
        check("rand_tx_hold", 32'(out_d), 32'(enc(d[W-1:0])));
        tick(1);
        n++;
      end
      if (n >= 60) begin tmo("rand_tx_null"); return; end
      tick($urandom_range(0, 3));
      out_e = 1'b1;
    end
  endtask

  initial begin
    rst_n    = 1'b1;
    in_d     = '0;
    rx_ready = 1'b0;
    tx_data  = '0;
    tx_valid = 1'b0;
    out_e    = 1'b1;

    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_e", 32'(in_e), 1);
    check("rst_out_d", 32'(out_d), 0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_tx_ready", 32'(tx_ready), 1);
    tick(3);
    rst_n = 1'b1;
    tick(3);

    // Receive vectors.
    vt[0] = '{enc(9'h000), 1'b1, 9'h000};
    vt[1] = '{enc(9'h1FF), 1'b1, 9'h1FF};
    vt[2] = '{enc(9'h155), 1'b1, 9'h155};
    vt[3] = '{enc(9'h0AA), 1'b1, 9'h0AA};
    vt[4] = '{enc(9'h1A5) | (RW'(3) << 6), 1'b0, 9'h000};
    vt[5] = '{enc(9'h1A5) & ~(RW'(3) << 16), 1'b0, 9'h000};

    for (int i = 0; i < 6; i++) begin
      in_d     = vt[i].rails;
      rx_ready = 1'b0;
      tick(2);
      check($sformatf("vec%0d_early", i), 32'(rx_valid), 0);
      tick(1);
      check($sformatf("vec%0d_valid", i), 32'(rx_valid), 32'(vt[i].cap));
      check($sformatf("vec%0d_in_e", i), 32'(in_e), 32'(!vt[i].cap));
      if (vt[i].cap) check($sformatf("vec%0d_data", i), 32'(rx_data), 32'(vt[i].word));
      tick(3);
      check($sformatf("vec%0d_valid_late", i), 32'(rx_valid), 32'(vt[i].cap));
      in_d = '0;
      tick(3);
      check($sformatf("vec%0d_in_e_idle", i), 32'(in_e), 1);
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      check($sformatf("vec%0d_consumed", i), 32'(rx_valid), 0);
    end

    // Receive back-pressure.
    in_d = enc(9'h1A5);
    tick(3);
    check("bp_first_valid", 32'(rx_valid), 1);
    check("bp_first_data", 32'(rx_data), 32'h1A5);
    in_d = '0;
    tick(3);
    check("bp_first_in_e", 32'(in_e), 1);
    in_d = enc(9'h0F0);
    tick(6);
    check("bp_hold_valid", 32'(rx_valid), 1);
    check("bp_hold_data", 32'(rx_data), 32'h1A5);
    check("bp_hold_in_e", 32'(in_e), 1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check("bp_release", 32'(rx_valid), 0);
    tick(1);
    check("bp_second_valid", 32'(rx_valid), 1);
    check("bp_second_data", 32'(rx_data), 32'h0F0);
    check("bp_second_in_e", 32'(in_e), 0);
    in_d = '0;
    tick(3);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check("bp_drain", 32'(rx_valid), 0);

    // Send with out_e already high.
    tx_data  = 9'h155;
    tx_valid = 1'b1;
    check("tx_ready_idle", 32'(tx_ready), 1);
    tick(1);
    tx_valid = 1'b0;
    check("tx_ready_busy", 32'(tx_ready), 0);
    check("tx_rails_pre", 32'(out_d), 0);
    tick(1);
    check("tx_rails", 32'(out_d), 32'(enc(9'h155)));
    out_e = 1'b0;
    tick(2);
    check("tx_rails_hold", 32'(out_d), 32'(enc(9'h155)));
    tick(1);
    check("tx_rails_null", 32'(out_d), 0);
    check("tx_ready_back", 32'(tx_ready), 1);

    // Send with out_e low; inputs are ignored while busy.
    tx_data  = 9'h003;
    tx_valid = 1'b1;
    tick(1);
    tx_data  = 9'h1FF;
    tick(4);
    check("tx2_wait_rails", 32'(out_d), 0);
    check("tx2_wait_ready", 32'(tx_ready), 0);
    out_e = 1'b1;
    tick(2);
    check("tx2_sync_rails", 32'(out_d), 0);
    tick(1);
    tx_valid = 1'b0;
    check("tx2_rails", 32'(out_d), 32'(enc(9'h003)));
    out_e = 1'b0;
    tick(3);
    check("tx2_null", 32'(out_d), 0);
    check("tx2_ready", 32'(tx_ready), 1);
    out_e = 1'b1;
    tick(3);

    // Reset in the middle of both halves.
    in_d     = enc(9'h0AA);
    tx_data  = 9'h1FF;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tick(2);
    check("mid_pre_valid", 32'(rx_valid), 1);
    check("mid_pre_rails", 32'(out_d), 32'(enc(9'h1FF)));
    #1 rst_n = 1'b0;
    #1;
    check("mid_in_e", 32'(in_e), 1);
    check("mid_rx_valid", 32'(rx_valid), 0);
    check("mid_rx_data", 32'(rx_data), 0);
    check("mid_out_d", 32'(out_d), 0);
    check("mid_tx_ready", 32'(tx_ready), 1);
    in_d  = '0;
    out_e = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(3);

    // Randomized traffic on both halves at once.
    fork
      rx_sender();
      rx_consumer();
      tx_producer();
      tx_responder();
    join
    check("rand_rx_left", 32'(rx_q.size()), 0);
    check("rand_tx_left", 32'(tx_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/e1ofn_sync_bridge.md
Name: e1ofn_sync_bridge

Overview:
- Bidirectional bridge between asynchronous four-phase e1ofN channels (M digits, N rails per digit, active-high enable) and synchronous valid/ready handshakes.
- Receive half decodes an incoming e1ofN token into a binary word for clocked logic.
- Send half encodes a binary word from clocked logic onto an outgoing e1ofN channel.
- Sits at the boundary of every clocked block wrapped into the async NoC.

Parameters:
M, 9, number of 1-of-N digits per token
N, 2, rails per digit (N>=2)
B, clog2(N), bits per digit (derived)
W, M*B, binary data width (derived; 9 at defaults)

Ports:
CLK  input  1  clock, rising edge
_RESET  input  1  asynchronous active-low reset
in_d  input  M*N  incoming rails; digit i = in_d[i*N +: N]
in_e  output  1  enable/ack to upstream async sender
rx_data  output  W  received word
rx_valid  output  1  rx_data holds an unconsumed token
rx_ready  input  1  consumer accepts rx_data this cycle
tx_data  input  W  word to send
tx_valid  input  1  producer offers tx_data
tx_ready  output  1  bridge can accept tx_data this cycle
out_d  output  M*N  outgoing rails, registered
out_e  input  1  enable/ack from downstream async receiver

Behaviour:
- One clock, CLK; reset _RESET is asynchronous, active-low. All state flops clear immediately when _RESET falls.
- Reset values: in_e=1, rx_valid=0, rx_data=0, out_d=0 (neutral), tx_ready=1, all synchronizer flops=0.
- Encoding:
  - Digit i carries value v (0..N-1) by raising rail i*N+v.
  - Binary bits [i*B +: B] = v.
  - Neutral = all rails of the digit low.
  - For N=2: rail 2i means bit i=0; rail 2i+1 means bit i=1.
- Synchronizers:
  - in_d and out_e each pass through two flops before any use.
  - Only second-stage values are used.
- Receive FSM:
  - RX_IDLE: in_e=1.
    - A digit is complete when exactly one of its rails is high; a multi-hot digit is incomplete (protocol violation, no capture).
    - When all M digits are complete and rx_valid=0: capture the decoded word into rx_data, set rx_valid=1, drop in_e to 0, go to RX_ACK.
    - If rx_valid=1, wait.
  - RX_ACK: in_e=0. When all synchronized rails are low, raise in_e=1 and go to RX_IDLE.
  - rx_valid clears on the edge where rx_valid&&rx_ready; rx_data holds until then.
  - Latency: rails stable before edge k, then rx_valid=1 and in_e=0 after edge k+2.
  - Buffer full back-pressures the async side: in_e stays 1 but no capture occurs, so the sender holds its rails.
- Send FSM:
  - TX_IDLE: tx_ready=1. On tx_valid&&tx_ready, latch tx_data and go to TX_WAIT_EN.
  - TX_WAIT_EN: tx_ready=0. When synced out_e=1, drive out_d with the one-hot encoding of the latched word and go to TX_WAIT_ACK.
  - TX_WAIT_ACK: hold out_d. When synced out_e=0, set out_d=0 and go to TX_IDLE.
  - out_d changes only via a single registered update per transition; no glitches, and never two rails of one digit high.
  - Latency: if out_e is already 1 and synced, rails are asserted one edge after acceptance.
- Receive and send halves are fully independent.
- Reset mid-operation: both halves return to idle with the reset values above. The external async partner must also be reset.
- tx_data and tx_valid are ignored outside TX_IDLE.

Test Plan:
- Reset (M=9, N=2):
  - Assert _RESET=0 with no clock edge.
  - Expect in_e=1, out_d=0, rx_valid=0, tx_ready=1 immediately.
- Receive 9'h1A5:
  - Drive in_d with rails for bits 1_1010_0101, hold rx_ready=0.
  - Expect rx_valid=1, rx_data=9'h1A5, in_e=0 two edges after sync.
  - Set in_d=0; expect in_e=1 after sync.
  - Set rx_ready=1; expect rx_valid drops.
- Receive back-pressure:
  - Present 9'h0F0 while rx_valid still holds 9'h1A5.
  - Expect no capture and rx_data unchanged.
  - After rx_ready pulse, expect 9'h0F0 captured.
- Invalid and partial codes:
  - One digit with both rails high, or only 8 digits valid.
  - Expect no rx_valid and in_e stays 1.
- Send 9'h155 with out_e=1:
  - Pulse tx_valid.
  - Expect tx_ready=0 and out_d = one-hot of 1_0101_0101 one edge after sync.
  - Drop out_e; expect out_d=0 and tx_ready=1.
- Send with out_e=0:
  - Accept 9'h003.
  - Expect out_d stays 0 until out_e rises, then encodes 9'h003.
